pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master drives the decode/execute/memory stage fields; the slave returns stall and md status.
interface pipe_hazard_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic [4:0]  E_waddr;
  logic [4:0]  M_waddr;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        D_is_md;
  logic        E_md_start;
  logic        E_md_op;
  logic        D_stall;
  logic        E_clr;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cycles;

  modport master (
    output D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt,
    output E_waddr, M_waddr, E_tnew, M_tnew,
    output D_is_md, E_md_start, E_md_op,
    input  D_stall, E_clr, md_busy, md_cnt, stall_cycles
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt,
    input  E_waddr, M_waddr, E_tnew, M_tnew,
    input  D_is_md, E_md_start, E_md_op,
    output D_stall, E_clr, md_busy, md_cnt, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Tuse/Tnew data-hazard stall, mult/div occupancy counter and optional stall statistics.
// Define PIPE_STALL_CNT_EN to build the 32-bit stall_cycles counter; otherwise it reads 0.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic                 clk,
  input logic                 reset,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
    $error("MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("DIV_CYCLES must be in 1..15");
  end

  // A source conflicts when its producer cannot forward before the consumer needs it.
  function automatic logic src_hazard(input logic [4:0] src,  input logic [1:0] tuse,
                                      input logic [4:0] waddr, input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != 2'd3) && (src == waddr) && (tuse < tnew);
  endfunction

  logic [3:0] md_cnt_r;
  logic       data_stall_s;
  logic       md_busy_s;
  logic       stall_s;

  assign data_stall_s = src_hazard(hz.D_rs_addr, hz.D_tuse_rs, hz.E_waddr, hz.E_tnew)
                      | src_hazard(hz.D_rt_addr, hz.D_tuse_rt, hz.E_waddr, hz.E_tnew)
                      | src_hazard(hz.D_rs_addr, hz.D_tuse_rs, hz.M_waddr, hz.M_tnew)
                      | src_hazard(hz.D_rt_addr, hz.D_tuse_rt, hz.M_waddr, hz.M_tnew);

  // The start cycle itself counts as busy so a back-to-back md instruction stalls at once.
  assign md_busy_s = hz.E_md_start | (md_cnt_r != 4'd0);
  assign stall_s   = data_stall_s | (hz.D_is_md & md_busy_s);

  assign hz.D_stall = stall_s;
  assign hz.E_clr   = stall_s;
  assign hz.md_busy = md_busy_s;
  assign hz.md_cnt  = md_cnt_r;

  // Occupancy countdown; a start while still counting is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_r <= 4'd0;
    end else if (md_cnt_r != 4'd0) begin
      md_cnt_r <= md_cnt_r - 4'd1;
    end else if (hz.E_md_start) begin
      md_cnt_r <= hz.E_md_op ? DIV_LOAD : MULT_LOAD;
    end else begin
      md_cnt_r <= 4'd0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles_r;

  // Free-running stall statistic, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_s) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign hz.stall_cycles = stall_cycles_r;
`else
  assign hz.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PIPE_STALL_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    hz.D_rs_addr = 5'd0;  hz.D_rt_addr = 5'd0;
    hz.D_tuse_rs = 2'd3;  hz.D_tuse_rt = 2'd3;
    hz.E_waddr   = 5'd0;  hz.M_waddr   = 5'd0;
    hz.E_tnew    = 2'd0;  hz.M_tnew    = 2'd0;
    hz.D_is_md   = 1'b0;  hz.E_md_start = 1'b0;  hz.E_md_op = 1'b0;

    // Reset state
    #2;
    chk("rst_md_cnt", 32'(hz.md_cnt), 32'd0);
    chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_stall", 32'(hz.D_stall), 32'd0);
    chk("rst_stall_cycles", hz.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Load-use on rs against E, held for 7 stalled cycles
    hz.E_waddr = 5'd8; hz.E_tnew = 2'd2; hz.D_rs_addr = 5'd8; hz.D_tuse_rs = 2'd1;
    #1;
    chk("load_use_stall", 32'(hz.D_stall), 32'd1);
    chk("load_use_eclr", 32'(hz.E_clr), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("load_use_hold", 32'(hz.D_stall), 32'd1);
    end
    hz.E_tnew = 2'd1;
    #1;
    chk("tnew1_no_stall", 32'(hz.D_stall), 32'd0);
    chk("tnew1_no_eclr", 32'(hz.E_clr), 32'd0);
    chk("stall_cnt_7", hz.stall_cycles, cnt_exp(32'd7));

    // Register 0 never stalls
    hz.D_rs_addr = 5'd0; hz.D_tuse_rs = 2'd3;
    hz.E_waddr = 5'd0; hz.E_tnew = 2'd2; hz.D_rt_addr = 5'd0; hz.D_tuse_rt = 2'd0;
    #1;
    chk("reg0_no_stall", 32'(hz.D_stall), 32'd0);

    // rt against M stage, then tuse=3 and tuse==tnew cases
    hz.M_waddr = 5'd5; hz.M_tnew = 2'd1; hz.D_rt_addr = 5'd5; hz.D_tuse_rt = 2'd0;
    #1;
    chk("m_rt_stall", 32'(hz.D_stall), 32'd1);
    hz.D_tuse_rt = 2'd3;
    #1;
    chk("m_rt_unused", 32'(hz.D_stall), 32'd0);
    hz.D_tuse_rt = 2'd1;
    #1;
    chk("m_rt_tuse_eq_tnew", 32'(hz.D_stall), 32'd0);
    hz.M_waddr = 5'd6; hz.D_tuse_rt = 2'd0;
    #1;
    chk("m_rt_other_reg", 32'(hz.D_stall), 32'd0);
    hz.M_waddr = 5'd0; hz.M_tnew = 2'd0; hz.D_rt_addr = 5'd0; hz.D_tuse_rt = 2'd3;
    hz.E_tnew = 2'd0;

    // Div: md instruction in D stalls the start cycle plus 10 counted cycles
    hz.E_md_start = 1'b1; hz.E_md_op = 1'b1; hz.D_is_md = 1'b1;
    #1;
    chk("div_start_busy", 32'(hz.md_busy), 32'd1);
    chk("div_start_stall", 32'(hz.D_stall), 32'd1);
    chk("div_start_cnt", 32'(hz.md_cnt), 32'd0);
    tick();
    hz.E_md_start = 1'b0;
    for (int k = 10; k >= 1; k--) begin
      #1;
      chk("div_cnt", 32'(hz.md_cnt), 32'(k));
      chk("div_stall", 32'(hz.D_stall), 32'd1);
      tick();
    end
    chk("div_cnt_done", 32'(hz.md_cnt), 32'd0);
    chk("div_busy_done", 32'(hz.md_busy), 32'd0);
    chk("div_stall_done", 32'(hz.D_stall), 32'd0);
    chk("stall_cnt_18", hz.stall_cycles, cnt_exp(32'd18));
    hz.D_is_md = 1'b0;

    // Mult, then a second start at md_cnt=3 is ignored
    hz.E_md_start = 1'b1; hz.E_md_op = 1'b0;
    tick();
    hz.E_md_start = 1'b0;
    #1;
    chk("mult_load", 32'(hz.md_cnt), 32'd5);
    tick();
    tick();
    chk("mult_cnt3", 32'(hz.md_cnt), 32'd3);
    hz.E_md_start = 1'b1; hz.E_md_op = 1'b1;
    tick();
    hz.E_md_start = 1'b0;
    #1;
    chk("restart_ign_2", 32'(hz.md_cnt), 32'd2);
    tick();
    chk("restart_ign_1", 32'(hz.md_cnt), 32'd1);
    tick();
    chk("restart_ign_0", 32'(hz.md_cnt), 32'd0);
    chk("restart_busy_0", 32'(hz.md_busy), 32'd0);

    // Asynchronous reset mid-mult at md_cnt=4
    hz.E_md_start = 1'b1; hz.E_md_op = 1'b0;
    tick();
    hz.E_md_start = 1'b0;
    tick();
    chk("pre_rst_cnt4", 32'(hz.md_cnt), 32'd4);
    reset = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(hz.md_cnt), 32'd0);
    chk("async_rst_busy", 32'(hz.md_busy), 32'd0);
    chk("async_rst_stall_cycles", hz.stall_cycles, 32'd0);
    hz.E_md_start = 1'b1;
    #1;
    chk("rst_busy_follows_start", 32'(hz.md_busy), 32'd1);
    tick();
    chk("rst_holds_cnt", 32'(hz.md_cnt), 32'd0);
    hz.E_md_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Counting resumes on the first edge after release
    hz.E_md_start = 1'b1; hz.E_md_op = 1'b0;
    tick();
    hz.E_md_start = 1'b0;
    #1;
    chk("resume_load", 32'(hz.md_cnt), 32'd5);
    hz.D_is_md = 1'b1;
    tick();
    tick();
    hz.D_is_md = 1'b0;
    #1;
    chk("resume_cnt3", 32'(hz.md_cnt), 32'd3);
    chk("stall_cnt_after_rst", hz.stall_cycles, cnt_exp(32'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
